nanorv32_ahb_arbiter: RTL and testbench

- Two-master, one-slave AHB-lite arbiter for the nanorv32_simpleahb subsystem.
- M0 is the instruction-fetch port and M1 is the load/store data port; both share a single AHB-lite slave path (code RAM plus peripheral decoder).
- M1 has fixed priority. A starvation counter guarantees forward progress for fetch.
- Address and data phases are tracked separately so the bus stays pipelined across owner changes.

---
 rtl/nanorv32_ahb_arbiter_pkg.sv | 22 ++
 rtl/nanorv32_ahb_arb_prio.sv | 54 +++++
 rtl/nanorv32_ahb_arbiter.sv | 124 ++++++++++++
 tb/tb_nanorv32_ahb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_ahb_arbiter_pkg.sv
// Shared AHB-lite encodings and master indices for the nanorv32_simpleahb
// arbiter and its grant/priority sub-block.
package nanorv32_ahb_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        MST_IFETCH = 1'b0,
        MST_DATA   = 1'b1
    } mst_e;

    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans != HTRANS_IDLE;
    endfunction

endpackage

// File: rtl/nanorv32_ahb_arb_prio.sv
// Address-phase grant decision: fixed priority for the data port, with a
// saturating starvation counter that lets instruction fetch through.
module nanorv32_ahb_arb_prio
    import nanorv32_ahb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic hold,
    input  logic s_hready,
    output logic gnt
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    mst_e gnt_r;
    mst_e gnt_sel;
    logic [CNT_W-1:0] starve_cnt;

    // A held address (slave wait state) keeps its owner; idle bus parks.
    always_comb begin
        gnt_sel = gnt_r;
        if (hold) begin
            gnt_sel = gnt_r;
        end else if (req0 && (!req1 || starve_cnt == CNT_MAX)) begin
            gnt_sel = MST_IFETCH;
        end else if (req1) begin
            gnt_sel = MST_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_r      <= MST_DATA;
            starve_cnt <= '0;
        end else begin
            gnt_r <= gnt_sel;
            if (req0 && s_hready) begin
                if (gnt_sel == MST_IFETCH) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    assign gnt = (gnt_sel == MST_DATA);

endmodule

// File: rtl/nanorv32_ahb_arbiter.sv
// Two-master / one-slave AHB-lite arbiter: fetch port M0, load/store port M1,
// with separately tracked address and data phases.
module nanorv32_ahb_arbiter
    import nanorv32_ahb_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic              m0_hready,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic              m1_hready,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic              s_hready,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hresp
);

    logic req0;
    logic req1;
    logic gnt;
    logic hold_r;
    logic dph_valid_r;
    logic dph_owner_r;
    logic own0;
    logic own1;

    // Requests are masked during reset so the slave sees IDLE immediately.
    assign req0 = rst_n && htrans_active(m0_htrans);
    assign req1 = rst_n && htrans_active(m1_htrans);

    nanorv32_ahb_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .hold     (hold_r),
        .s_hready (s_hready),
        .gnt      (gnt)
    );

    // Burst continuity cannot survive an owner change, so every beat goes out as NONSEQ.
    always_comb begin
        s_haddr  = m0_haddr;
        s_hwrite = m0_hwrite;
        s_hsize  = m0_hsize;
        s_htrans = req0 ? HTRANS_NONSEQ : HTRANS_IDLE;
        if (gnt == MST_DATA) begin
            s_haddr  = m1_haddr;
            s_hwrite = m1_hwrite;
            s_hsize  = m1_hsize;
            s_htrans = req1 ? HTRANS_NONSEQ : HTRANS_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_r      <= 1'b0;
            dph_valid_r <= 1'b0;
            dph_owner_r <= MST_DATA;
        end else begin
            hold_r <= (s_htrans != HTRANS_IDLE) && !s_hready;
            if (s_hready) begin
                dph_valid_r <= (s_htrans != HTRANS_IDLE);
                dph_owner_r <= gnt;
            end
        end
    end

    assign own0 = dph_valid_r && (dph_owner_r == MST_IFETCH);
    assign own1 = dph_valid_r && (dph_owner_r == MST_DATA);

    always_comb begin
        s_hwdata = '0;
        if (own0) begin
            s_hwdata = m0_hwdata;
        end else if (own1) begin
            s_hwdata = m1_hwdata;
        end
    end

    // A requester that lost arbitration is stalled; otherwise it follows the slave.
    always_comb begin
        m0_hready = 1'b1;
        m1_hready = 1'b1;
        if (own0) begin
            m0_hready = s_hready;
        end else if (req0) begin
            m0_hready = (gnt == MST_IFETCH) ? s_hready : 1'b0;
        end
        if (own1) begin
            m1_hready = s_hready;
        end else if (req1) begin
            m1_hready = (gnt == MST_DATA) ? s_hready : 1'b0;
        end
    end

    assign m0_hresp  = own0 ? s_hresp : HRESP_OKAY;
    assign m1_hresp  = own1 ? s_hresp : HRESP_OKAY;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// Directed scoreboard bench for nanorv32_ahb_arbiter: the driver queues
// hand-computed expectations per cycle, a monitor checks them mid-cycle.
module tb_nanorv32_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_haddr, m1_haddr;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic        m0_hready, m1_hready;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hresp, m1_hresp;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [31:0] s_hwdata;
    logic        s_hready;
    logic [31:0] s_hrdata;
    logic        s_hresp;

    nanorv32_ahb_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_haddr  (m0_haddr),
        .m0_htrans (m0_htrans),
        .m0_hwrite (m0_hwrite),
        .m0_hsize  (m0_hsize),
        .m0_hwdata (m0_hwdata),
        .m0_hready (m0_hready),
        .m0_hrdata (m0_hrdata),
        .m0_hresp  (m0_hresp),
        .m1_haddr  (m1_haddr),
        .m1_htrans (m1_htrans),
        .m1_hwrite (m1_hwrite),
        .m1_hsize  (m1_hsize),
        .m1_hwdata (m1_hwdata),
        .m1_hready (m1_hready),
        .m1_hrdata (m1_hrdata),
        .m1_hresp  (m1_hresp),
        .s_haddr   (s_haddr),
        .s_htrans  (s_htrans),
        .s_hwrite  (s_hwrite),
        .s_hsize   (s_hsize),
        .s_hwdata  (s_hwdata),
        .s_hready  (s_hready),
        .s_hrdata  (s_hrdata),
        .s_hresp   (s_hresp)
    );

    always #5 clk = ~clk;

    typedef enum int {
        SEL_HADDR, SEL_HTRANS, SEL_HWRITE, SEL_HWDATA,
        SEL_M0_RDY, SEL_M1_RDY, SEL_M0_RESP, SEL_M1_RESP,
        SEL_M0_RDATA, SEL_M1_RDATA, SEL_STARVE, SEL_DPH_VALID
    } sel_e;

    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] probe(input sel_e s);
        case (s)
            SEL_HADDR:     return s_haddr;
            SEL_HTRANS:    return 32'(s_htrans);
            SEL_HWRITE:    return 32'(s_hwrite);
            SEL_HWDATA:    return s_hwdata;
            SEL_M0_RDY:    return 32'(m0_hready);
            SEL_M1_RDY:    return 32'(m1_hready);
            SEL_M0_RESP:   return 32'(m0_hresp);
            SEL_M1_RESP:   return 32'(m1_hresp);
            SEL_M0_RDATA:  return m0_hrdata;
            SEL_M1_RDATA:  return m1_hrdata;
            SEL_STARVE:    return 32'(dut.u_prio.starve_cnt);
            SEL_DPH_VALID: return 32'(dut.dph_valid_r);
            default:       return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                                 input logic [1:0] t1, input logic [31:0] a1, input logic w1,
                                 input logic rdy, input logic resp, input logic [31:0] rdata);
        m0_htrans = t0; m0_haddr = a0; m0_hwrite = w0;
        m1_htrans = t1; m1_haddr = a1; m1_hwrite = w1;
        s_hready  = rdy; s_hresp = resp; s_hrdata = rdata;
    endtask

    task automatic checkOutput(input sel_e s, input logic [31:0] e, input string n);
        exp_t r;
        r.cyc = cyc; r.sel = s; r.exp = e; r.name = n;
        sbq.push_back(r);
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("[TB] FAIL %s: missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
                end else begin
                    act = probe(e.sel);
                    if (act !== e.exp) begin
                        errors++;
                        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                                 e.name, act, e.exp, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        m0_hsize = 3'd2; m1_hsize = 3'd2;
        m0_hwdata = 32'h1111_1111; m1_hwdata = 32'hA5A5_0001;
        applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle;
        nextCycle;
        checkOutput(SEL_HTRANS,  32'd0, "reset_htrans");
        checkOutput(SEL_M0_RDY,  32'd1, "reset_m0_hready");
        checkOutput(SEL_M1_RDY,  32'd1, "reset_m1_hready");
        checkOutput(SEL_M0_RESP, 32'd0, "reset_m0_hresp");
        checkOutput(SEL_M1_RESP, 32'd0, "reset_m1_hresp");
        checkOutput(SEL_STARVE,  32'd0, "reset_starve");

        // M1 read at 0x100, data one cycle later
        nextCycle;
        rst_n = 1'b1;
        applyStimulus(IDLE, 32'h0, 1'b0, NONSEQ, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HADDR,  32'h100, "m1rd_haddr");
        checkOutput(SEL_HTRANS, 32'd2,   "m1rd_htrans");
        checkOutput(SEL_M1_RDY, 32'd1,   "m1rd_m1_hready");
        checkOutput(SEL_M0_RDY, 32'd1,   "m1rd_m0_hready");
        nextCycle;
        applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h100, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        checkOutput(SEL_M1_RDATA, 32'hDEAD_BEEF, "m1rd_hrdata");
        checkOutput(SEL_M1_RDY,   32'd1,         "m1rd_dph_hready");
        checkOutput(SEL_M0_RDY,   32'd1,         "m1rd_dph_m0_hready");
        checkOutput(SEL_HTRANS,   32'd0,         "m1rd_dph_htrans");

        // Both request every cycle: four M1 grants, then M0
        for (int i = 0; i < 4; i++) begin
            nextCycle;
            applyStimulus(NONSEQ, 32'h200, 1'b0, NONSEQ, 32'h300 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput(SEL_HADDR,  32'h300 + 32'(4 * i), "starve_m1_haddr");
            checkOutput(SEL_M0_RDY, 32'd0,                "starve_m0_stalled");
        end
        nextCycle;
        applyStimulus(NONSEQ, 32'h200, 1'b0, NONSEQ, 32'h310, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_STARVE, 32'd4,   "starve_saturated");
        checkOutput(SEL_HADDR,  32'h200, "starve_m0_haddr");
        checkOutput(SEL_M0_RDY, 32'd1,   "starve_m0_granted");
        nextCycle;
        applyStimulus(IDLE, 32'h200, 1'b0, NONSEQ, 32'h314, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_STARVE, 32'd0,   "starve_cleared");
        checkOutput(SEL_HADDR,  32'h314, "starve_back_to_m1");
        checkOutput(SEL_M0_RDY, 32'd1,   "starve_m0_dph_ready");
        nextCycle;
        applyStimulus(IDLE, 32'h200, 1'b0, IDLE, 32'h314, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HTRANS, 32'd0, "starve_idle");

        // M0 read then M1 write, slave stretches M0 data phase by 2 waits
        nextCycle;
        applyStimulus(NONSEQ, 32'h400, 1'b0, IDLE, 32'h314, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HADDR,  32'h400, "pipe_m0_haddr");
        checkOutput(SEL_M0_RDY, 32'd1,   "pipe_m0_hready");
        for (int w = 0; w < 2; w++) begin
            nextCycle;
            applyStimulus(IDLE, 32'h400, 1'b0, NONSEQ, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput(SEL_HADDR,  32'h500,      "pipe_wait_m1_haddr");
            checkOutput(SEL_HTRANS, 32'd2,        "pipe_wait_htrans");
            checkOutput(SEL_HWRITE, 32'd1,        "pipe_wait_hwrite");
            checkOutput(SEL_M0_RDY, 32'd0,        "pipe_wait_m0_hready");
            checkOutput(SEL_M1_RDY, 32'd0,        "pipe_wait_m1_hready");
            checkOutput(SEL_HWDATA, 32'h1111_1111, "pipe_wait_hwdata_m0");
        end
        nextCycle;
        applyStimulus(IDLE, 32'h400, 1'b0, NONSEQ, 32'h500, 1'b1, 1'b1, 1'b0, 32'hCAFE_0400);
        checkOutput(SEL_HADDR,    32'h500,       "pipe_done_m1_haddr");
        checkOutput(SEL_M0_RDATA, 32'hCAFE_0400, "pipe_m0_hrdata");
        checkOutput(SEL_M0_RDY,   32'd1,         "pipe_done_m0_hready");
        checkOutput(SEL_M1_RDY,   32'd1,         "pipe_done_m1_hready");
        nextCycle;
        applyStimulus(IDLE, 32'h400, 1'b0, IDLE, 32'h500, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HWDATA, 32'hA5A5_0001, "pipe_m1_hwdata");
        checkOutput(SEL_M1_RDY, 32'd1,         "pipe_m1_dph_hready");
        checkOutput(SEL_HTRANS, 32'd0,         "pipe_idle_htrans");
        nextCycle;
        applyStimulus(IDLE, 32'h400, 1'b0, IDLE, 32'h500, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HWDATA, 32'h0, "pipe_hwdata_cleared");

        // M1 write to unmapped address, two-cycle ERROR; M0 waits behind it
        nextCycle;
        applyStimulus(IDLE, 32'h400, 1'b0, NONSEQ, 32'hF000_0000, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HADDR, 32'hF000_0000, "err_m1_haddr");
        nextCycle;
        applyStimulus(NONSEQ, 32'h600, 1'b0, IDLE, 32'hF000_0000, 1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput(SEL_HADDR,   32'h600, "err1_m0_haddr");
        checkOutput(SEL_M1_RESP, 32'd1,   "err1_m1_hresp");
        checkOutput(SEL_M0_RESP, 32'd0,   "err1_m0_hresp");
        checkOutput(SEL_M1_RDY,  32'd0,   "err1_m1_hready");
        checkOutput(SEL_M0_RDY,  32'd0,   "err1_m0_stalled");
        nextCycle;
        applyStimulus(NONSEQ, 32'h600, 1'b0, IDLE, 32'hF000_0000, 1'b1, 1'b1, 1'b1, 32'h0);
        checkOutput(SEL_HADDR,   32'h600, "err2_m0_haddr_held");
        checkOutput(SEL_M1_RESP, 32'd1,   "err2_m1_hresp");
        checkOutput(SEL_M0_RESP, 32'd0,   "err2_m0_hresp");
        checkOutput(SEL_M1_RDY,  32'd1,   "err2_m1_hready");
        checkOutput(SEL_M0_RDY,  32'd1,   "err2_m0_hready");
        nextCycle;
        applyStimulus(IDLE, 32'h600, 1'b0, IDLE, 32'hF000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_600D);
        checkOutput(SEL_M0_RDATA, 32'h0000_600D, "err_m0_hrdata");
        checkOutput(SEL_M0_RDY,   32'd1,         "err_m0_dph_hready");
        checkOutput(SEL_M1_RESP,  32'd0,         "err_m1_hresp_clear");

        // Both idle: bus parks on the last granted master (M0)
        nextCycle;
        applyStimulus(IDLE, 32'h600, 1'b0, IDLE, 32'hF000_0000, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HTRANS, 32'd0,   "park_htrans");
        checkOutput(SEL_HADDR,  32'h600, "park_haddr");
        checkOutput(SEL_M0_RDY, 32'd1,   "park_m0_hready");
        checkOutput(SEL_M1_RDY, 32'd1,   "park_m1_hready");

        // Reset during a stalled M0 data phase
        nextCycle;
        applyStimulus(NONSEQ, 32'h700, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HADDR, 32'h700, "rst_m0_haddr");
        nextCycle;
        rst_n = 1'b0;
        applyStimulus(IDLE, 32'h700, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput(SEL_M0_RDY, 32'd0, "rst_m0_wait");
        nextCycle;
        applyStimulus(IDLE, 32'h700, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput(SEL_HTRANS,    32'd0, "rst_mid_htrans");
        checkOutput(SEL_DPH_VALID, 32'd0, "rst_mid_dph_valid");
        checkOutput(SEL_M0_RDY,    32'd1, "rst_mid_m0_hready");
        checkOutput(SEL_M1_RDY,    32'd1, "rst_mid_m1_hready");
        checkOutput(SEL_M0_RESP,   32'd0, "rst_mid_m0_hresp");
        checkOutput(SEL_HWDATA,    32'd0, "rst_mid_hwdata");
        nextCycle;
        rst_n = 1'b1;
        applyStimulus(IDLE, 32'h700, 1'b0, NONSEQ, 32'h800, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput(SEL_HADDR,  32'h800, "post_rst_m1_haddr");
        checkOutput(SEL_HTRANS, 32'd2,   "post_rst_htrans");
        checkOutput(SEL_M1_RDY, 32'd1,   "post_rst_m1_hready");
        nextCycle;
        applyStimulus(IDLE, 32'h700, 1'b0, IDLE, 32'h800, 1'b0, 1'b1, 1'b0, 32'h0);

        nextCycle;
        nextCycle;
        if (sbq.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
            errors += sbq.size();
            checks += sbq.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
